imm_encoder: RTL
================

// Module: imm_encoder
// PURPOSE
//  Inverse of the immediate extender: packs a 32-bit signed immediate into the RV32I I/S/B/J
//  bit positions of an instruction word. Pipelined, with valid/ready on both sides. Sits in the
//  boot/self-test program builder, feeding the instruction-memory writer: out_addr plus out_instr.
//  For every legal immediate, re-extending out_instr with the same immsrc returns in_imm exactly.
// PARAMETERS
//  ADDR_W     32      width of the out_addr write-address counter
//  BASE_ADDR  32'h0   value out_addr takes after reset; must be a multiple of 4
// PORTS
//  clk        in   1       single clock, rising edge
//  reset_n    in   1       synchronous, active-low reset
//  in_valid   in   1       request present
//  in_ready   out  1       request accepted when in_valid && in_ready at clk edge
//  in_immsrc  in   2       00=I 01=S 10=B 11=J (same coding as the extender)
//  in_imm     in   32      signed byte-offset immediate
//  in_base    in   32      instruction with non-immediate fields set; immediate field bits ignored
//  out_valid  out  1       encoded word present
//  out_ready  in   1       consumer takes word when out_valid && out_ready at clk edge
//  out_instr  out  32      encoded instruction
//  out_err    out  2       [0] range error, [1] alignment error, for this word
//  out_addr   out  ADDR_W  byte address assigned to this word
//  err_sticky out  1       OR of every out_err bit ever emitted; cleared only by reset
// BEHAVIOUR
//  Reset (reset_n=0 at edge):
//   - s1_valid=0, s2_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_sticky=0.
//   - Any in-flight request is discarded; in_ready=1 in the first cycle after reset.
//  Pipeline: S1 captures the request; S2 holds the encoded result and drives all out_* ports.
//   - adv2 = !s2_valid || out_ready
//   - in_ready = !s1_valid || adv2 (combinational; no in_valid -> in_ready path)
//   - Latency: accept at edge N -> out_valid high after edge N+1. Throughput: 1 word per cycle.
//   - While out_valid && !out_ready, out_instr, out_err and out_addr hold stable.
//     S1 holds its request; no request is dropped or duplicated.
//  Encoding (combinational, between S1 and S2):
//   - mask: I={[31:20]}, S/B={[31:25],[11:7]}, J={[31:12]}
//   - out_instr = (base & ~mask) | field
//   - I: field[31:20] = imm[11:0]
//   - S: field[31:25] = imm[11:5], field[11:7] = imm[4:0]
//   - B: bit31=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], bit7=imm[11]
//   - J: bit31=imm[20], [30:21]=imm[10:1], bit20=imm[11], [19:12]=imm[19:12]
//  Error checks (word is still emitted, truncated as encoded):
//   - Range error if imm is not the sign extension of: bit 11 (I/S), bit 12 (B), bit 20 (J).
//   - Alignment error if imm[0]=1 for B or J. Never raised for I/S.
//  Address: out_addr increments by 4 on each output handshake, modulo 2^ADDR_W (wraps, no flag).
//  err_sticky: set in the cycle after the first handshake whose out_err != 0.
//  Simultaneous events: accept and emit in the same edge are both honoured; S1 refills as S2 drains.
// STRUCTURE
//  Package riscv_imm_pkg:
//   - localparams IMM_I/IMM_S/IMM_B/IMM_J (2'b00..2'b11)
//   - function imm_mask(immsrc) -> 32-bit mask
//   - shared by the extender and this encoder
//  Sub-module imm_pack (combinational): inputs immsrc, imm, base; outputs instr, err[1:0].
//  The top module holds only the S1/S2 registers, handshake logic, address counter and sticky flag.
// TESTING
//  1. I, imm=32'hFFFFFFFF, base=32'h00000013 -> out_instr=32'hFFF00013, err=00, out_addr=BASE_ADDR
//  2. S, imm=2044, base=32'h00002023 -> 32'h7E002E23. B, imm=-4, base=32'h63 -> 32'hFE000EE3.
//     J, imm=2048, base=32'h6F -> 32'h0010006F. All err=00; out_addr steps by 4.
//  3. I imm=2048 -> err=01. B imm=3 -> err=10. J imm=32'h00100000 -> err=01.
//     err_sticky=1 after the first of these; stays 1 until reset.
//  4. Back-to-back stream of 8 requests, out_ready toggling 1010...:
//     all 8 words emitted in order, outputs stable while stalled, none lost or repeated.
//  5. Pull reset_n=0 for 1 cycle with both stages full ->
//     out_valid=0, out_addr=BASE_ADDR, err_sticky=0 next cycle; next request encodes correctly.
//  6. Random legal (immsrc, imm), checked against the extender model: re-extend(out_instr)==in_imm.

Source files
------------

// File: rtl/riscv_imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_imm_pkg
//  Description : RV32I immediate-format codes and the per-format mask of the
//                instruction bits that carry the immediate. Shared by the
//                immediate extender and the immediate encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_imm_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Instruction bits owned by the immediate for each format.
    function automatic logic [31:0] imm_mask(input logic [1:0] immsrc);
        logic [31:0] m;
        case (immsrc)
            IMM_I:        m = 32'hFFF0_0000;   // [31:20]
            IMM_S, IMM_B: m = 32'hFE00_0F80;   // [31:25], [11:7]
            default:      m = 32'hFFFF_F000;   // [31:12]
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pack
//  Description : Combinational packer. Scatters a signed byte-offset
//                immediate into the I/S/B/J field positions of a base
//                instruction and flags range / alignment problems.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_pack
    import riscv_imm_pkg::*;
(
    input  logic [1:0]  immsrc,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] instr,
    output logic [1:0]  err
);

    logic [31:0] w_field;
    logic        w_range_err;
    logic        w_align_err;

    // Field placement and error detection per immediate format.
    always_comb begin
        w_field     = '0;
        w_range_err = 1'b0;
        w_align_err = 1'b0;
        case (immsrc)
            IMM_I: begin
                w_field[31:20] = imm[11:0];
                w_range_err    = (imm[31:11] != {21{imm[11]}});
            end
            IMM_S: begin
                w_field[31:25] = imm[11:5];
                w_field[11:7]  = imm[4:0];
                w_range_err    = (imm[31:11] != {21{imm[11]}});
            end
            IMM_B: begin
                w_field[31]    = imm[12];
                w_field[30:25] = imm[10:5];
                w_field[11:8]  = imm[4:1];
                w_field[7]     = imm[11];
                w_range_err    = (imm[31:12] != {20{imm[12]}});
                w_align_err    = imm[0];
            end
            default: begin
                w_field[31]    = imm[20];
                w_field[30:21] = imm[10:1];
                w_field[20]    = imm[11];
                w_field[19:12] = imm[19:12];
                w_range_err    = (imm[31:20] != {12{imm[20]}});
                w_align_err    = imm[0];
            end
        endcase
    end

    // Immediate bits of the base are discarded before the field is merged in.
    assign instr = (base & ~imm_mask(immsrc)) | w_field;
    assign err   = {w_align_err, w_range_err};

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : Two-stage valid/ready pipeline packing signed immediates
//                into RV32I instruction words, tagging each emitted word with
//                a sequential byte address and a sticky error summary.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_encoder
    import riscv_imm_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_immsrc,
    input  logic [31:0]       in_imm,
    input  logic [31:0]       in_base,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [1:0]        out_err,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_sticky
);

    // Stage 1: captured request
    logic        r_s1_valid;
    logic [1:0]  r_s1_immsrc;
    logic [31:0] r_s1_imm;
    logic [31:0] r_s1_base;

    // Stage 2: encoded result driving the output ports
    logic              r_s2_valid;
    logic [31:0]       r_out_instr;
    logic [1:0]        r_out_err;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_err_sticky;

    logic        w_adv2;
    logic        w_out_fire;
    logic [31:0] w_pack_instr;
    logic [1:0]  w_pack_err;

    // Stage 2 may load whenever it is empty or being drained this edge;
    // stage 1 may load whenever it is empty or moving into stage 2.
    assign w_adv2     = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_adv2;
    assign w_out_fire = r_s2_valid && out_ready;

    imm_pack u_pack (
        .immsrc (r_s1_immsrc),
        .imm    (r_s1_imm),
        .base   (r_s1_base),
        .instr  (w_pack_instr),
        .err    (w_pack_err)
    );

    // Stage 1 request register: refills whenever it can pass its content on.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_immsrc <= IMM_I;
            r_s1_imm    <= '0;
            r_s1_base   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_immsrc <= in_immsrc;
                r_s1_imm    <= in_imm;
                r_s1_base   <= in_base;
            end
        end
    end

    // Stage 2 result register: loads the packed word, holds while stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s2_valid  <= 1'b0;
            r_out_instr <= '0;
            r_out_err   <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_instr <= w_pack_instr;
                r_out_err   <= w_pack_err;
            end
        end
    end

    // Address of the word currently presented; steps once per handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_addr <= BASE_ADDR;
        end else if (w_out_fire) begin
            r_out_addr <= r_out_addr + ADDR_W'(4);
        end
    end

    // Sticky error: latches any error bit of a word actually handed off.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err_sticky <= 1'b0;
        end else if (w_out_fire && (r_out_err != 2'b00)) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_instr  = r_out_instr;
    assign out_err    = r_out_err;
    assign out_addr   = r_out_addr;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire
